var_isqrt_unit: RTL

VAR_ISQRT_UNIT -- requirements
Module: var_isqrt_unit

---
 rtl/ln_pkg.sv | 46 ++++
 rtl/isqrt_seed_lut.sv | 16 +
 rtl/var_isqrt_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ln_pkg.sv
// Shared definitions for the variance / inverse-square-root unit: widths, FSM encoding, seed table helper.
package ln_pkg;
    localparam int EX_W       = 16;
    localparam int EX2_W      = 32;
    localparam int ISQRT_W    = 16;
    localparam int ISQRT_FRAC = 15;
    localparam int LUT_DEPTH  = 64;
    localparam int LUT_IDX_W  = 6;
    localparam int M_W        = 8;   // mantissa in [1,4), Q2.6
    localparam int K_W        = 4;
    localparam int T_W        = 20;  // m*y^2 in Q.15, headroom above 3.0
    localparam logic [ISQRT_W-1:0] ISQRT_ONE = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_VAR  = 3'd2,
        ST_NORM = 3'd3,
        ST_SEED = 3'd4,
        ST_NR   = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    // Q1.15 of 1/sqrt((idx+0.5)/16) = floor(sqrt(2^35/(2*idx+1))), capped at 1.0
    function automatic logic [ISQRT_W-1:0] seed_calc(input int idx);
        logic [39:0] num;
        logic [39:0] trial;
        logic [17:0] root;
        num  = 40'h08_0000_0000 / 40'(2 * idx + 1);
        root = 18'd0;
        for (int b = 17; b >= 0; b--) begin
            trial = 40'(root | (18'd1 << b));
            trial = trial * trial;
            if (trial <= num) begin
                root = root | (18'd1 << b);
            end else begin
                root = root;
            end
        end
        if (root >= 18'h08000) begin
            return ISQRT_ONE;
        end else begin
            return root[15:0];
        end
    endfunction
endpackage

// File: rtl/isqrt_seed_lut.sv
// Combinational Newton-Raphson seed: Q2.4 mantissa index -> Q1.15 1/sqrt at the bin centre.
module isqrt_seed_lut
    import ln_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] i_idx,
    output logic [ISQRT_W-1:0]   o_seed
);
    logic [ISQRT_W-1:0] table_s [LUT_DEPTH];

    // Entries below 16 are unreachable for a normalised mantissa and clamp to 1.0
    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_tbl
        assign table_s[g] = seed_calc(g);
    end

    assign o_seed = table_s[i_idx];
endmodule

// File: rtl/var_isqrt_unit.sv
// Variance E[x^2]-E[x]^2 and Q1.15 1/sqrt(var+1) via LUT seed plus Newton-Raphson.
// Define VAR_ISQRT_NR2_EN for two NR iterations (latency T+8) instead of one (T+6).
module var_isqrt_unit
    import ln_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_Ex_valid,
    input  logic signed [EX_W-1:0]   i_Ex,
    input  logic                     i_Ex2_valid,
    input  logic [EX2_W-1:0]         i_Ex2,
    output logic                     o_done,
    output logic [EX2_W-1:0]         o_var,
    output logic [ISQRT_W-1:0]       o_isqrt,
    output logic                     o_busy,
    output logic                     o_drop
);
`ifdef VAR_ISQRT_NR2_EN
    localparam logic [1:0] NR_LAST = 2'd3;
`else
    localparam logic [1:0] NR_LAST = 2'd1;
`endif
    localparam logic [T_W-1:0] THREE_Q15 = 20'd98304;

    state_e                  state_q, state_d;
    logic                    ex_flag_q, ex_flag_d, ex2_flag_q, ex2_flag_d;
    logic signed [EX_W-1:0]  ex_q, ex_d;
    logic [EX2_W-1:0]        ex2_q, ex2_d, var_q, var_d;
    logic [M_W-1:0]          m_q, m_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [ISQRT_W-1:0]      y_q, y_d;
    logic [T_W-1:0]          t_q, t_d;
    logic [1:0]              nr_cnt_q, nr_cnt_d;
    logic                    done_q, done_d, busy_q, busy_d, drop_q, drop_d;
    logic [EX2_W-1:0]        var_out_q, var_out_d;
    logic [ISQRT_W-1:0]      isqrt_q, isqrt_d;

    logic signed [31:0]      prod_s;
    logic [32:0]             v_ext_s;
    logic [31:0]             v_s;
    logic [K_W-1:0]          k_s;
    logic [M_W-1:0]          m_s;
    logic [ISQRT_W-1:0]      seed_s;
    logic [47:0]             ysq_s, tprod_s, ynew_wide_s;
    logic [T_W-1:0]          diff_s;
    logic [ISQRT_W-1:0]      ynew_s;

    isqrt_seed_lut u_seed (
        .i_idx  (m_q[M_W-1:2]),
        .o_seed (seed_s)
    );

    // Datapath arithmetic shared by VAR, NORM and NR
    always_comb begin
        prod_s  = ex_q * ex_q;
        v_ext_s = {1'b0, var_q} + 33'd1;
        v_s     = v_ext_s[32] ? 32'hFFFF_FFFF : v_ext_s[31:0];
        k_s     = 4'd0;
        for (int i = 0; i < 32; i++) begin
            if (v_s[i]) begin
                k_s = 4'(i / 2);
            end else begin
                k_s = k_s;
            end
        end
        m_s         = 8'({v_s, 6'b0} >> {k_s, 1'b0});
        ysq_s       = 48'(y_q) * 48'(y_q);
        tprod_s     = ysq_s * 48'(m_q);
        diff_s      = (t_q < THREE_Q15) ? (THREE_Q15 - t_q) : 20'd0;
        ynew_wide_s = 48'(y_q) * 48'(diff_s);
        // (3-t)/2 and the Q.30 -> Q.15 rescale fold into one shift of 16
        ynew_s      = (ynew_wide_s[47:16] > 32'h0000_8000) ? ISQRT_ONE : ynew_wide_s[31:16];
    end

    // Next-state, operand capture and registered-output computation
    always_comb begin
        state_d    = state_q;
        ex_flag_d  = ex_flag_q;
        ex2_flag_d = ex2_flag_q;
        ex_d       = ex_q;
        ex2_d      = ex2_q;
        var_d      = var_q;
        m_d        = m_q;
        k_d        = k_q;
        y_d        = y_q;
        t_d        = t_q;
        nr_cnt_d   = nr_cnt_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (i_Ex_valid) begin
                    ex_d      = i_Ex;
                    ex_flag_d = 1'b1;
                end else begin
                    ex_d = ex_q;
                end
                if (i_Ex2_valid) begin
                    ex2_d      = i_Ex2;
                    ex2_flag_d = 1'b1;
                end else begin
                    ex2_d = ex2_q;
                end
                if (ex_flag_q && ex2_flag_q) begin
                    state_d    = ST_VAR;
                    ex_flag_d  = 1'b0;
                    ex2_flag_d = 1'b0;
                end else if (i_Ex_valid || i_Ex2_valid) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_VAR: begin
                var_d   = (32'(prod_s) > ex2_q) ? 32'd0 : (ex2_q - 32'(prod_s));
                state_d = ST_NORM;
            end
            ST_NORM: begin
                m_d     = m_s;
                k_d     = k_s;
                state_d = ST_SEED;
            end
            ST_SEED: begin
                y_d      = seed_s;
                nr_cnt_d = 2'd0;
                state_d  = ST_NR;
            end
            ST_NR: begin
                if (!nr_cnt_q[0]) begin
                    t_d = 20'(tprod_s >> 21);
                end else begin
                    y_d = ynew_s;
                end
                if (nr_cnt_q == NR_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    nr_cnt_d = nr_cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d    = !(state_d inside {ST_IDLE, ST_WAIT});
        drop_d    = !(state_q inside {ST_IDLE, ST_WAIT}) && (i_Ex_valid || i_Ex2_valid);
        done_d    = (state_d == ST_DONE);
        var_out_d = done_d ? var_q : 32'd0;
        isqrt_d   = done_d ? (y_d >> k_q) : 16'd0;
    end

    // State, operand latches, datapath and output registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            ex_flag_q  <= 1'b0;
            ex2_flag_q <= 1'b0;
            ex_q       <= 16'sd0;
            ex2_q      <= 32'd0;
            var_q      <= 32'd0;
            m_q        <= 8'd0;
            k_q        <= 4'd0;
            y_q        <= 16'd0;
            t_q        <= 20'd0;
            nr_cnt_q   <= 2'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            var_out_q  <= 32'd0;
            isqrt_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            ex_flag_q  <= ex_flag_d;
            ex2_flag_q <= ex2_flag_d;
            ex_q       <= ex_d;
            ex2_q      <= ex2_d;
            var_q      <= var_d;
            m_q        <= m_d;
            k_q        <= k_d;
            y_q        <= y_d;
            t_q        <= t_d;
            nr_cnt_q   <= nr_cnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            var_out_q  <= var_out_d;
            isqrt_q    <= isqrt_d;
        end
    end

    assign o_done  = done_q;
    assign o_var   = var_out_q;
    assign o_isqrt = isqrt_q;
    assign o_busy  = busy_q;
    assign o_drop  = drop_q;
endmodule
